pll_reset_ctrl: RTL

Reset sequencer and lock supervisor for the PLL block, the controller on the other end of its rst/locked pair. It drives the PLL reset input, watches the PLL locked output, and retries with bounded reset pulses when lock is not reached. It releases a system reset only after lock has stayed stable for a set time, and re-sequences on any loss of lock. It runs on the free-running PLL reference clock and sits between the PLL and the design's reset tree.

---
 rtl/pll_reset_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: drives PLL reset with bounded retries and releases system reset
// once lock has stayed stable; re-sequences on any loss of lock.
module pll_reset_ctrl #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_locked,
    output logic       o_pll_rst,
    output logic       o_sys_rst,
    output logic       o_fault,
    output logic [7:0] o_lock_loss_count
);
    localparam int MAXC = (RESET_CYCLES > LOCK_TIMEOUT)
        ? ((RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE)
        : ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);
    localparam int CW = $clog2(MAXC) + 1;
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [CW-1:0] RC_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] LS_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] MR = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUNNING, FAULT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retries_q, retries_d;
    logic [7:0]    loss_q, loss_d;
    logic [1:0]    sync_q;
    logic          boot_q;
    logic          pll_rst_q, sys_rst_q, fault_q;
    logic          locked_s;

    assign locked_s          = sync_q[1];
    assign o_pll_rst         = pll_rst_q;
    assign o_sys_rst         = sys_rst_q;
    assign o_fault           = fault_q;
    assign o_lock_loss_count = loss_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        retries_d = retries_q;
        loss_d    = loss_q;
        case (state_q)
            // the first cycle after reset release is not counted toward the pulse
            RESET_PLL: begin
                if (boot_q) cnt_d = '0;
                else if (cnt_q == RC_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) state_d = STABILIZE;
                else if (cnt_q == LT_LAST) begin
                    state_d   = (retries_q < MR) ? RESET_PLL : FAULT;
                    retries_d = (retries_q < MR) ? retries_q + RW'(1) : retries_q;
                end
            end
            STABILIZE: begin
                if (!locked_s) state_d = WAIT_LOCK;
                else if (cnt_q == LS_LAST) state_d = RUNNING;
            end
            RUNNING: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    state_d   = RESET_PLL;
                    retries_d = '0;
                    loss_d    = (loss_q == 8'hff) ? loss_q : loss_q + 8'd1;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q    <= '0;
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
            loss_q    <= '0;
            boot_q    <= 1'b1;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_locked};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            loss_q    <= loss_d;
            boot_q    <= 1'b0;
            pll_rst_q <= state_d == RESET_PLL;
            sys_rst_q <= state_d != RUNNING;
            fault_q   <= state_d == FAULT;
        end
    end
endmodule
